// File: rtl/cache_meta_ctrl_if.sv
// Signal bundle between the cache meta controller and its surroundings:
// lookup request/response, invalidate, refill handshake and meta store port.
interface cache_meta_ctrl_if #(
  parameter int ADDR_BIT   = 32,
  parameter int BLKIDX_BIT = 4,
  parameter int OFFSET_BIT = 4
);
  localparam int TAG_BIT = ADDR_BIT - BLKIDX_BIT - OFFSET_BIT;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_BIT-1:0]   req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_hit;
  logic [BLKIDX_BIT-1:0] resp_blkidx;
  logic                  inv_valid;
  logic                  inv_ready;
  logic [BLKIDX_BIT-1:0] inv_blkidx;
  logic                  refill_req;
  logic [ADDR_BIT-1:0]   refill_addr;
  logic                  refill_done;
  logic                  meta_wen;
  logic [BLKIDX_BIT-1:0] meta_blkidx;
  logic [TAG_BIT:0]      meta_wdata;
  logic [TAG_BIT:0]      meta_rdata;

  // The controller side drives the handshake responses and the meta store port.
  modport master (
    input  req_valid, req_addr, resp_ready, inv_valid, inv_blkidx,
           refill_done, meta_rdata,
    output req_ready, resp_valid, resp_hit, resp_blkidx, inv_ready,
           refill_req, refill_addr, meta_wen, meta_blkidx, meta_wdata
  );

  modport slave (
    output req_valid, req_addr, resp_ready, inv_valid, inv_blkidx,
           refill_done, meta_rdata,
    input  req_ready, resp_valid, resp_hit, resp_blkidx, inv_ready,
           refill_req, refill_addr, meta_wen, meta_blkidx, meta_wdata
  );
endinterface

// File: rtl/cache_meta_ctrl.sv
// Lookup/refill controller for a direct-mapped cache. Owns the {valid, tag}
// meta store port, sweeps it to invalid after reset, and sequences refills.
module cache_meta_ctrl #(
  parameter int ADDR_BIT   = 32,
  parameter int BLKIDX_BIT = 4,
  parameter int OFFSET_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  cache_meta_ctrl_if.master bus
);
  localparam int TAG_BIT  = ADDR_BIT - BLKIDX_BIT - OFFSET_BIT;
  localparam int LINE_BIT = ADDR_BIT - OFFSET_BIT;
  localparam logic [BLKIDX_BIT-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {INIT, IDLE, CHECK, REFILL, RESP} state_t;

  state_t                state;
  state_t                next_state;
  logic [BLKIDX_BIT-1:0] sweep_cnt;
  logic [LINE_BIT-1:0]   line_q;
  logic                  resp_hit_q;
  logic [BLKIDX_BIT-1:0] resp_blkidx_q;

  logic [BLKIDX_BIT-1:0] req_idx;
  logic [BLKIDX_BIT-1:0] lat_idx;
  logic [TAG_BIT-1:0]    lat_tag;
  logic                  hit;
  logic                  accept;

  // Only the line address is kept; the byte offset never matters after accept.
  assign req_idx = bus.req_addr[BLKIDX_BIT+OFFSET_BIT-1:OFFSET_BIT];
  assign lat_idx = line_q[BLKIDX_BIT-1:0];
  assign lat_tag = line_q[LINE_BIT-1:BLKIDX_BIT];
  assign hit     = bus.meta_rdata[TAG_BIT] && (bus.meta_rdata[TAG_BIT-1:0] == lat_tag);
  assign accept  = (state == IDLE) && !bus.inv_valid && bus.req_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (sweep_cnt == LAST_IDX) next_state = IDLE;
      IDLE:    if (accept) next_state = CHECK;
      CHECK:   next_state = hit ? RESP : REFILL;
      REFILL:  if (bus.refill_done) next_state = RESP;
      RESP:    if (bus.resp_ready) next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  // Response fields are captured on entry to RESP so they stay stable while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep_cnt     <= '0;
      line_q        <= '0;
      resp_hit_q    <= 1'b0;
      resp_blkidx_q <= '0;
    end else begin
      if (state == INIT) sweep_cnt <= sweep_cnt + 1'b1;
      if (accept) line_q <= bus.req_addr[ADDR_BIT-1:OFFSET_BIT];
      if (state == CHECK && hit) begin
        resp_hit_q    <= 1'b1;
        resp_blkidx_q <= lat_idx;
      end
      if (state == REFILL && bus.refill_done) begin
        resp_hit_q    <= 1'b0;
        resp_blkidx_q <= lat_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready   = 1'b0;
    bus.inv_ready   = 1'b0;
    bus.meta_wen    = 1'b0;
    bus.meta_blkidx = lat_idx;
    bus.meta_wdata  = '0;
    case (state)
      INIT: begin
        bus.meta_wen    = 1'b1;
        bus.meta_blkidx = sweep_cnt;
      end
      IDLE: begin
        bus.req_ready   = !bus.inv_valid;
        bus.inv_ready   = 1'b1;
        bus.meta_blkidx = req_idx;
        if (bus.inv_valid) begin
          bus.meta_wen    = 1'b1;
          bus.meta_blkidx = bus.inv_blkidx;
        end
      end
      REFILL: begin
        if (bus.refill_done) begin
          bus.meta_wen   = 1'b1;
          bus.meta_wdata = {1'b1, lat_tag};
        end
      end
      default: ;
    endcase
  end

  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_hit    = resp_hit_q;
  assign bus.resp_blkidx = resp_blkidx_q;
  assign bus.refill_req  = (state == REFILL);
  assign bus.refill_addr = {line_q, {OFFSET_BIT{1'b0}}};
endmodule

// File: tb/tb_cache_meta_ctrl.sv
// Directed bench for cache_meta_ctrl with a behavioural meta store
// (combinational read, clocked write, no reset).
module tb_cache_meta_ctrl;
  localparam int ADDR_BIT   = 32;
  localparam int BLKIDX_BIT = 4;
  localparam int OFFSET_BIT = 4;
  localparam int TAG_BIT    = ADDR_BIT - BLKIDX_BIT - OFFSET_BIT;

  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;

  cache_meta_ctrl_if #(.ADDR_BIT(ADDR_BIT), .BLKIDX_BIT(BLKIDX_BIT), .OFFSET_BIT(OFFSET_BIT)) bus ();

  cache_meta_ctrl #(.ADDR_BIT(ADDR_BIT), .BLKIDX_BIT(BLKIDX_BIT), .OFFSET_BIT(OFFSET_BIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [TAG_BIT:0] meta_mem [1<<BLKIDX_BIT];

  assign bus.meta_rdata = meta_mem[bus.meta_blkidx];

  always @(posedge clk) begin
    if (bus.meta_wen) meta_mem[bus.meta_blkidx] <= bus.meta_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sweep check: 16 write cycles of zero at ascending indices, then IDLE.
  task automatic check_sweep(input logic late_done);
    for (int i = 0; i < 16; i++) begin
      bus.refill_done = late_done && (i < 2);
      #1;
      check_output("sweep_wen", bus.meta_wen, 1);
      check_output("sweep_idx", bus.meta_blkidx, i);
      check_output("sweep_wdata", bus.meta_wdata, 0);
      check_output("sweep_req_ready", bus.req_ready, 0);
      check_output("sweep_inv_ready", bus.inv_ready, 0);
      tick();
    end
    bus.refill_done = 1'b0;
    #1;
    check_output("post_sweep_req_ready", bus.req_ready, 1);
    check_output("post_sweep_wen", bus.meta_wen, 0);
    check_output("post_sweep_refill_req", bus.refill_req, 0);
    check_output("post_sweep_resp_valid", bus.resp_valid, 0);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic exp_hit,
                                input int refill_wait, input int hold);
    logic [3:0]  idx;
    logic [24:0] wdata;
    logic [31:0] line_addr;
    idx       = addr[7:4];
    wdata     = {1'b1, addr[31:8]};
    line_addr = {addr[31:4], 4'h0};
    bus.req_addr  = addr;
    bus.req_valid = 1'b1;
    #1;
    check_output("accept_req_ready", bus.req_ready, 1);
    check_output("accept_blkidx", bus.meta_blkidx, idx);
    tick();
    bus.req_valid = 1'b0;
    #1;
    check_output("check_resp_valid", bus.resp_valid, 0);
    check_output("check_refill_req", bus.refill_req, 0);
    check_output("check_wen", bus.meta_wen, 0);
    check_output("check_blkidx", bus.meta_blkidx, idx);
    tick();
    if (!exp_hit) begin
      check_output("refill_req", bus.refill_req, 1);
      check_output("refill_addr", bus.refill_addr, line_addr);
      check_output("refill_resp_valid", bus.resp_valid, 0);
      for (int w = 0; w < refill_wait; w++) begin
        tick();
        check_output("refill_req_held", bus.refill_req, 1);
        check_output("refill_addr_held", bus.refill_addr, line_addr);
        check_output("refill_wen_idle", bus.meta_wen, 0);
      end
      bus.refill_done = 1'b1;
      #1;
      check_output("fill_wen", bus.meta_wen, 1);
      check_output("fill_blkidx", bus.meta_blkidx, idx);
      check_output("fill_wdata", bus.meta_wdata, wdata);
      tick();
      bus.refill_done = 1'b0;
      #1;
    end
    for (int h = 0; h < hold; h++) begin
      check_output("stall_resp_valid", bus.resp_valid, 1);
      check_output("stall_resp_hit", bus.resp_hit, exp_hit);
      check_output("stall_resp_blkidx", bus.resp_blkidx, idx);
      check_output("stall_refill_req", bus.refill_req, 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    check_output("resp_valid", bus.resp_valid, 1);
    check_output("resp_hit", bus.resp_hit, exp_hit);
    check_output("resp_blkidx", bus.resp_blkidx, idx);
    check_output("resp_req_ready", bus.req_ready, 0);
    check_output("resp_inv_ready", bus.inv_ready, 0);
    tick();
    bus.resp_ready = 1'b0;
    #1;
    check_output("done_resp_valid", bus.resp_valid, 0);
    check_output("done_req_ready", bus.req_ready, 1);
  endtask

  task automatic invalidate_with_req(input logic [3:0] idx, input logic [31:0] addr);
    bus.inv_valid  = 1'b1;
    bus.inv_blkidx = idx;
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    #1;
    check_output("inv_ready", bus.inv_ready, 1);
    check_output("inv_req_ready", bus.req_ready, 0);
    check_output("inv_wen", bus.meta_wen, 1);
    check_output("inv_blkidx", bus.meta_blkidx, idx);
    check_output("inv_wdata", bus.meta_wdata, 0);
    tick();
    bus.inv_valid = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check_output("inv_stay_idle", bus.req_ready, 1);
    check_output("inv_no_check", bus.resp_valid, 0);
  endtask

  initial begin
    assert_count    = 0;
    fail_count      = 0;
    rst             = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.resp_ready  = 1'b0;
    bus.inv_valid   = 1'b0;
    bus.inv_blkidx  = '0;
    bus.refill_done = 1'b0;

    #3;
    check_output("rst_meta_wen", bus.meta_wen, 1);
    check_output("rst_req_ready", bus.req_ready, 0);
    check_output("rst_refill_req", bus.refill_req, 0);
    check_output("rst_resp_valid", bus.resp_valid, 0);
    check_output("rst_refill_addr", bus.refill_addr, 0);
    tick();
    tick();
    rst = 1'b1;
    $display("[TB] reset released, checking sweep");
    check_sweep(1'b0);

    $display("[TB] cold miss on 0x00001234");
    apply_stimulus(32'h0000_1234, 1'b0, 5, 0);
    $display("[TB] hit on 0x00001238");
    apply_stimulus(32'h0000_1238, 1'b1, 0, 0);

    $display("[TB] conflict eviction at idx 3");
    apply_stimulus(32'h0000_2234, 1'b0, 1, 0);
    apply_stimulus(32'h0000_1234, 1'b0, 0, 0);

    $display("[TB] invalidate beats request");
    invalidate_with_req(4'd3, 32'h0000_2234);
    apply_stimulus(32'h0000_2234, 1'b0, 2, 0);
    apply_stimulus(32'h0000_2238, 1'b1, 0, 3);
    invalidate_with_req(4'd3, 32'h0000_2234);
    apply_stimulus(32'h0000_2234, 1'b0, 0, 0);

    bus.refill_done = 1'b1;
    tick();
    bus.refill_done = 1'b0;
    #1;
    check_output("stray_done_refill_req", bus.refill_req, 0);
    check_output("stray_done_resp_valid", bus.resp_valid, 0);
    check_output("stray_done_req_ready", bus.req_ready, 1);

    $display("[TB] reset during refill");
    bus.req_addr  = 32'h0000_5670;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check_output("pre_rst_refill_req", bus.refill_req, 1);
    check_output("pre_rst_refill_addr", bus.refill_addr, 32'h0000_5670);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_rst_refill_req", bus.refill_req, 0);
    check_output("async_rst_meta_wen", bus.meta_wen, 1);
    check_output("async_rst_blkidx", bus.meta_blkidx, 0);
    check_output("async_rst_refill_addr", bus.refill_addr, 0);
    tick();
    rst = 1'b1;
    check_sweep(1'b1);

    apply_stimulus(32'h0000_1234, 1'b0, 0, 0);
    apply_stimulus(32'h0000_1230, 1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
